// File: rtl/angle_loader.sv
// angle_loader: streams 3-angle reference frames from memory into the angle shifter,
// with a drain gap per frame and an angle_valid strobe aligned to the shifter output.
`default_nettype none

module angle_loader #(
  parameter int ANGLE_DEPTH = 10,
  parameter int ADDR_WIDTH  = 12,
  parameter int FRAME_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic [ADDR_WIDTH-1:0]  i_base_addr,
  input  logic [FRAME_WIDTH-1:0] i_num_frames,
  input  logic                   i_hold,
  output logic                   o_mem_rd,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic [ANGLE_DEPTH-1:0] i_mem_rdata,
  output logic                   o_fill,
  output logic [ANGLE_DEPTH-1:0] o_fill_angle,
  output logic                   o_angle_valid,
  output logic                   o_busy,
  output logic                   o_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_DRAIN  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [1:0]             r_idx;
  logic [2:0]             r_cnt;
  logic [FRAME_WIDTH-1:0] r_num;
  logic [FRAME_WIDTH-1:0] r_frames;
  logic [ADDR_WIDTH-1:0]  r_ptr;
  logic [ADDR_WIDTH-1:0]  w_rd_addr;
  logic                   w_more;
  logic                   r_rd_d1;
  logic [2:0]             r_fill_dly;

  assign w_more    = (r_frames != r_num);
  assign w_rd_addr = (r_state == S_IDLE) ? i_base_addr : r_ptr;

  // DRAIN spans the two fill cycles plus the first drain cycle (count 0..2);
  // on the last frame it keeps counting to cover the shifter drain (count 3..5).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = (i_num_frames != '0) ? S_READ : S_FINISH;
      end
      S_READ: begin
        if (r_idx == 2'd2) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_cnt == 3'd2 && w_more) w_next = i_hold ? S_WAIT : S_READ;
        else if (r_cnt == 3'd5)      w_next = S_FINISH;
      end
      S_WAIT: begin
        if (!i_hold) w_next = S_READ;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= 2'd0;
      r_cnt    <= 3'd0;
      r_num    <= '0;
      r_frames <= '0;
      r_ptr    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          r_idx    <= 2'd0;
          r_cnt    <= 3'd0;
          r_frames <= '0;
          if (i_start) r_num <= i_num_frames;
        end
        S_READ: begin
          if (r_idx == 2'd2) begin
            r_idx    <= 2'd0;
            r_cnt    <= 3'd0;
            r_frames <= r_frames + FRAME_WIDTH'(1);
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        S_DRAIN: r_cnt <= r_cnt + 3'd1;
        default: ;
      endcase
      if (w_next == S_READ) r_ptr <= w_rd_addr + ADDR_WIDTH'(1);
    end
  end

  // Outputs are registered from the next state so they line up with the state cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mem_rd      <= 1'b0;
      o_mem_addr    <= '0;
      r_rd_d1       <= 1'b0;
      o_fill        <= 1'b0;
      o_fill_angle  <= '0;
      r_fill_dly    <= 3'd0;
      o_angle_valid <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_mem_rd      <= (w_next == S_READ);
      o_mem_addr    <= (w_next == S_READ) ? w_rd_addr : '0;
      r_rd_d1       <= o_mem_rd;
      o_fill        <= r_rd_d1;
      if (r_rd_d1)                  o_fill_angle <= i_mem_rdata;
      else if (r_state == S_FINISH) o_fill_angle <= '0;
      r_fill_dly    <= {r_fill_dly[1:0], o_fill};
      o_angle_valid <= r_fill_dly[2];
      o_busy        <= (w_next != S_IDLE);
      o_done        <= (w_next == S_FINISH);
    end
  end

endmodule

`default_nettype wire
